// File: rtl/key_slot_pkg.sv
// rtl/key_slot_pkg.sv - shared encodings for the key slot access controller
package key_slot_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_USE   = 2'b01,
        OP_LOCK  = 2'b10,
        OP_ZERO  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_DENIED  = 2'b01,
        ST_EMPTY   = 2'b10,
        ST_ABORTED = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_EXEC    = 2'b01,
        S_KEY_OUT = 2'b10,
        S_ZEROIZE = 2'b11
    } state_e;

endpackage

// File: rtl/key_slot_arbiter_rr_arbiter.sv
// rtl/key_slot_arbiter_rr_arbiter.sv - round-robin requester arbiter with one-hot and binary grant
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          found;

    // Scan starting at the pointer; IW-bit addition wraps because NUM_REQ is a power of 2.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + IW'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant = '0;
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/key_slot_arbiter.sv
// rtl/key_slot_arbiter.sv - key store access control: arbitration, slot policy and key delivery
module key_slot_arbiter
    import key_slot_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 4,
    parameter int KEY_W     = 128
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [2*NUM_REQ-1:0]                   req_op,
    input  logic [$clog2(NUM_SLOTS)*NUM_REQ-1:0]   req_slot,
    input  logic [KEY_W*NUM_REQ-1:0]               req_wdata,
    output logic                                   rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
    output logic [1:0]                             rsp_status,
    output logic                                   key_valid,
    output logic [KEY_W-1:0]                       key_data,
    input  logic                                   key_ready,
    input  logic                                   zeroize_all,
    output logic                                   busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(NUM_SLOTS);

    state_e            state, state_nx;
    status_e           status;
    logic [KEY_W-1:0]  slot_data  [NUM_SLOTS];
    logic [IW-1:0]     slot_owner [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid, slot_locked;

    logic [IW-1:0]     cur_id;
    op_e               cur_op;
    logic [SW-1:0]     cur_slot;
    logic [KEY_W-1:0]  cur_wdata;
    logic [SW-1:0]     zcnt;

    logic              arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]     grant_idx;
    logic              do_write, do_lock, do_clear;
    logic              sel_valid, sel_locked, owner_match;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign arb_en      = (state == S_IDLE) && !zeroize_all;
    assign req_ready   = grant;
    assign busy        = (state != S_IDLE);
    assign sel_valid   = slot_valid[cur_slot];
    assign sel_locked  = slot_locked[cur_slot];
    assign owner_match = (slot_owner[cur_slot] == cur_id);
    assign rsp_status  = status;
    assign rsp_id      = rsp_valid ? cur_id : '0;
    // Key material never leaves the block unless it is being offered to the crypto engine.
    assign key_data    = key_valid ? slot_data[cur_slot] : '0;

    always_comb begin
        state_nx  = state;
        rsp_valid = 1'b0;
        status    = ST_OK;
        key_valid = 1'b0;
        do_write  = 1'b0;
        do_lock   = 1'b0;
        do_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                if (zeroize_all) state_nx = S_ZEROIZE;
                else if (|grant) state_nx = S_EXEC;
            end
            S_EXEC: begin
                rsp_valid = 1'b1;
                state_nx  = S_IDLE;
                if (zeroize_all) begin
                    status   = ST_ABORTED;
                    state_nx = S_ZEROIZE;
                end else begin
                    case (cur_op)
                        OP_WRITE: if (sel_locked) status = ST_DENIED; else do_write = 1'b1;
                        OP_LOCK: begin
                            if (!sel_valid) status = ST_EMPTY;
                            else if (!owner_match) status = ST_DENIED;
                            else do_lock = 1'b1;
                        end
                        OP_ZERO: if (sel_valid && !owner_match) status = ST_DENIED; else do_clear = 1'b1;
                        default: begin
                            if (!sel_valid) status = ST_EMPTY;
                            else if (!owner_match) status = ST_DENIED;
                            else begin
                                // Key is offered immediately; a ready engine completes in this cycle.
                                key_valid = 1'b1;
                                if (!key_ready) begin
                                    rsp_valid = 1'b0;
                                    state_nx  = S_KEY_OUT;
                                end
                            end
                        end
                    endcase
                end
            end
            S_KEY_OUT: begin
                key_valid = 1'b1;
                if (zeroize_all) begin
                    rsp_valid = 1'b1;
                    status    = ST_ABORTED;
                    state_nx  = S_ZEROIZE;
                end else if (key_ready) begin
                    rsp_valid = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            default: begin
                if (zcnt == SW'(NUM_SLOTS - 1)) state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_id    <= '0;
            cur_op    <= OP_WRITE;
            cur_slot  <= '0;
            cur_wdata <= '0;
            zcnt      <= '0;
        end else begin
            state <= state_nx;
            zcnt  <= (state == S_ZEROIZE) ? zcnt + SW'(1) : '0;
            if (state == S_IDLE && |grant) begin
                cur_id    <= grant_idx;
                cur_op    <= op_e'(req_op[int'(grant_idx)*2 +: 2]);
                cur_slot  <= req_slot[int'(grant_idx)*SW +: SW];
                cur_wdata <= req_wdata[int'(grant_idx)*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_data[s]   <= '0;
                slot_owner[s]  <= '0;
                slot_valid[s]  <= 1'b0;
                slot_locked[s] <= 1'b0;
            end
        end else if (state == S_ZEROIZE) begin
            slot_data[zcnt]   <= '0;
            slot_owner[zcnt]  <= '0;
            slot_valid[zcnt]  <= 1'b0;
            slot_locked[zcnt] <= 1'b0;
        end else begin
            if (do_write) begin
                slot_data[cur_slot]  <= cur_wdata;
                slot_owner[cur_slot] <= cur_id;
                slot_valid[cur_slot] <= 1'b1;
            end
            if (do_lock) slot_locked[cur_slot] <= 1'b1;
            if (do_clear) begin
                slot_data[cur_slot]   <= '0;
                slot_owner[cur_slot]  <= '0;
                slot_valid[cur_slot]  <= 1'b0;
                slot_locked[cur_slot] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_slot_arbiter.sv
// tb/tb_key_slot_arbiter.sv - self-checking bench for key_slot_arbiter
module tb_key_slot_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [7:0]   req_slot;
    logic [511:0] req_wdata;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [1:0]   rsp_status;
    logic         key_valid;
    logic [127:0] key_data;
    logic         key_ready;
    logic         zeroize_all;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] m_data [4];
    bit           m_valid [4];
    bit           m_locked [4];
    int           m_owner [4];

    key_slot_arbiter #(.NUM_REQ(4), .NUM_SLOTS(4), .KEY_W(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_slot   (req_slot),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_status (rsp_status),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .zeroize_all(zeroize_all),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_data[s] = '0; m_valid[s] = 0; m_locked[s] = 0; m_owner[s] = 0;
        end
    endtask

    // Slot policy: ownership and lock rules, status 0 OK / 1 DENIED / 2 EMPTY.
    task automatic model_exec(input int id, input int op, input int slot, input logic [127:0] wd,
                              output logic [1:0] st, output bit go);
        st = 2'd0;
        go = 0;
        case (op)
            0: if (m_locked[slot]) st = 2'd1;
               else begin m_data[slot] = wd; m_valid[slot] = 1; m_owner[slot] = id; end
            1: if (!m_valid[slot]) st = 2'd2;
               else if (m_owner[slot] != id) st = 2'd1;
               else go = 1;
            2: if (!m_valid[slot]) st = 2'd2;
               else if (m_owner[slot] != id) st = 2'd1;
               else m_locked[slot] = 1;
            default: if (m_valid[slot] && m_owner[slot] != id) st = 2'd1;
               else begin m_data[slot] = '0; m_valid[slot] = 0; m_locked[slot] = 0; m_owner[slot] = 0; end
        endcase
    endtask

    // kd: cycles key_ready stays low after key_valid rises; negative leaves the key pending.
    task automatic issue(input int id, input int op, input int slot, input logic [127:0] wd, input int kd);
        logic [1:0]   st;
        bit           go;
        logic [127:0] kval;
        @(negedge clk);
        key_ready = 1'b0;
        req_valid = 4'(1 << id);
        req_op[id*2 +: 2]       = op[1:0];
        req_slot[id*2 +: 2]     = slot[1:0];
        req_wdata[id*128 +: 128] = wd;
        #1;
        chk("grant", 128'(req_ready), 128'(1 << id));
        @(negedge clk);
        req_valid = '0;
        key_ready = (kd == 0);
        #1;
        model_exec(id, op, slot, wd, st, go);
        if (!go) begin
            chk("rsp_valid", 128'(rsp_valid), 128'(1));
            chk("rsp_id", 128'(rsp_id), 128'(id));
            chk("rsp_status", 128'(rsp_status), 128'(st));
            chk("key_valid_idle", 128'(key_valid), 128'(0));
            chk("key_data_idle", key_data, 128'(0));
        end else begin
            kval = m_data[slot];
            chk("key_valid", 128'(key_valid), 128'(1));
            chk("key_data", key_data, kval);
            if (kd == 0) begin
                chk("use_rsp_valid", 128'(rsp_valid), 128'(1));
                chk("use_rsp_status", 128'(rsp_status), 128'(0));
                chk("use_rsp_id", 128'(rsp_id), 128'(id));
            end else begin
                chk("use_no_rsp", 128'(rsp_valid), 128'(0));
                if (kd > 0) begin
                    repeat (kd) begin
                        @(negedge clk); #1;
                        chk("hold_key_valid", 128'(key_valid), 128'(1));
                        chk("hold_key_data", key_data, kval);
                        chk("hold_no_rsp", 128'(rsp_valid), 128'(0));
                    end
                    @(negedge clk);
                    key_ready = 1'b1;
                    #1;
                    chk("use_rsp_valid", 128'(rsp_valid), 128'(1));
                    chk("use_rsp_status", 128'(rsp_status), 128'(0));
                    chk("use_rsp_id", 128'(rsp_id), 128'(id));
                end
            end
        end
    endtask

    initial begin
        int rr_order [5];
        int zid;
        logic [1:0] st;
        bit go;
        logic [127:0] k0;

        rr_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_slot = '0; req_wdata = '0;
        key_ready = 1'b0; zeroize_all = 1'b0;
        model_reset();
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_status", 128'(rsp_status), 128'(0));
        chk("rst_key_valid", 128'(key_valid), 128'(0));
        chk("rst_key_data", key_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: every requester zeroes its own (empty) slot, all held valid.
        for (int r = 0; r < 4; r++) begin
            req_op[r*2 +: 2] = 2'd3;
            req_slot[r*2 +: 2] = 2'(r);
        end
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            req_valid = 4'hF;
            #1;
            chk("rr_grant", 128'(req_ready), 128'(1 << rr_order[g]));
            model_exec(rr_order[g], 3, rr_order[g], '0, st, go);
            @(negedge clk); #1;
            chk("rr_no_grant_exec", 128'(req_ready), 128'(0));
            chk("rr_rsp_valid", 128'(rsp_valid), 128'(1));
            chk("rr_rsp_id", 128'(rsp_id), 128'(rr_order[g]));
            chk("rr_rsp_status", 128'(rsp_status), 128'(st));
        end
        @(negedge clk);
        req_valid = '0;

        k0 = 128'h0123456789ABCDEF0123456789ABCDEF;
        issue(0, 0, 1, k0, 0);
        issue(0, 1, 1, '0, 3);
        issue(2, 1, 1, '0, 0);
        issue(1, 1, 3, '0, 0);
        issue(0, 2, 1, '0, 0);
        issue(0, 0, 1, rand_key(), 0);
        issue(0, 1, 1, '0, 1);
        chk("locked_data_kept", m_data[1], k0);
        issue(0, 3, 1, '0, 0);
        issue(0, 1, 1, '0, 0);

        repeat (40) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  rand_key(), int'($urandom_range(0, 2)));
        end

        // Global zeroize pre-empting a pending key delivery.
        zid = m_valid[2] ? m_owner[2] : 0;
        issue(zid, 3, 2, '0, 0);
        issue(zid, 0, 2, rand_key(), 0);
        issue(zid, 1, 2, '0, -1);
        @(negedge clk);
        zeroize_all = 1'b1;
        #1;
        chk("abort_rsp_valid", 128'(rsp_valid), 128'(1));
        chk("abort_rsp_status", 128'(rsp_status), 128'(3));
        chk("abort_rsp_id", 128'(rsp_id), 128'(zid));
        @(negedge clk);
        zeroize_all = 1'b0;
        #1;
        chk("zeroize_key_valid", 128'(key_valid), 128'(0));
        chk("zeroize_key_data", key_data, 128'(0));
        chk("zeroize_busy", 128'(busy), 128'(1));
        repeat (3) begin
            @(negedge clk); #1;
            chk("zeroize_busy", 128'(busy), 128'(1));
        end
        @(negedge clk); #1;
        chk("zeroize_done", 128'(busy), 128'(0));
        model_reset();
        for (int s = 0; s < 4; s++) issue(s, 1, s, '0, 0);

        // Asynchronous reset while a key is on the bus.
        issue(1, 0, 0, rand_key(), 0);
        issue(1, 1, 0, '0, -1);
        @(negedge clk); #1;
        chk("pre_reset_key_valid", 128'(key_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_key_valid", 128'(key_valid), 128'(0));
        chk("areset_key_data", key_data, 128'(0));
        chk("areset_busy", 128'(busy), 128'(0));
        chk("areset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("areset_req_ready", 128'(req_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int s = 0; s < 4; s++) issue(3, 1, s, '0, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_slot_arbiter.md
# key_slot_arbiter

Access controller for the secret-key store: arbitrates key operations from NUM_REQ requesters onto a bank of NUM_SLOTS key registers, enforces per-slot ownership and locking, and delivers keys only over a dedicated valid/ready bus to the crypto engine. Requesters never receive key material; they receive only a status response. Sits between the bus-side requesters and the crypto core, and replaces any direct key register.

## Interface
- NUM_REQ, 4, number of requesters (power of 2, ≥2)
- NUM_SLOTS, 4, number of key slots (power of 2, ≥2)
- KEY_W, 128, key width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
- req_op  in  2*NUM_REQ  per-requester op: 00 WRITE, 01 USE, 10 LOCK, 11 ZERO
- req_slot  in  clog2(NUM_SLOTS)*NUM_REQ  per-requester slot index
- req_wdata  in  KEY_W*NUM_REQ  per-requester write data (WRITE only)
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  clog2(NUM_REQ)  requester being answered
- rsp_status  out  2  00 OK, 01 DENIED, 10 EMPTY, 11 ABORTED
- key_valid  out  1  key offered to the crypto engine
- key_data  out  KEY_W  key value; forced to 0 whenever key_valid=0
- key_ready  in  1  crypto engine accepts key
- zeroize_all  in  1  global zeroize request (level-sampled)
- busy  out  1  high in any state other than IDLE

## Operation
- Per-slot state: data[KEY_W], valid, locked, owner[clog2(NUM_REQ)]. Reset clears every field to 0. There are no hardcoded keys.
- FSM states: IDLE, EXEC, KEY_OUT, ZEROIZE.
- IDLE:
  - If zeroize_all=1, go to ZEROIZE. No grant is issued that cycle.
  - Otherwise, if any req_valid is high, the round-robin arbiter asserts req_ready for one winner. The controller captures id, op, slot and wdata, then goes to EXEC.
  - The round-robin pointer moves to winner+1 (mod NUM_REQ) after each grant.
- EXEC applies the slot policy:
  - WRITE: if locked, respond DENIED. Otherwise data=wdata, valid=1, owner=id, respond OK.
  - LOCK: if !valid, respond EMPTY. If owner≠id, respond DENIED. Otherwise locked=1, respond OK.
  - ZERO: if valid and owner≠id, respond DENIED. Otherwise clear data/valid/locked/owner and respond OK. Zeroing a locked slot by its owner is permitted.
  - USE: if !valid, respond EMPTY. If owner≠id, respond DENIED. Otherwise go to KEY_OUT with no response yet.
  - Every response returns the FSM to IDLE.
- KEY_OUT:
  - key_valid=1 and key_data=slot data.
  - When key_ready=1, the FSM pulses rsp_valid with status OK and returns to IDLE.
  - key_data must be stable while key_valid is held.
- ZEROIZE:
  - Clears one slot per cycle, indices 0..NUM_SLOTS-1, then returns to IDLE.
  - Further zeroize_all assertions during ZEROIZE are ignored.
  - No grants are issued.
- zeroize_all priority:
  - In EXEC or KEY_OUT, zeroize_all=1 pre-empts the current op. The op's slot update is not performed.
  - The FSM pulses rsp_valid with ABORTED and enters ZEROIZE in the same cycle.
  - key_valid is low from the next cycle.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_status=00, key_valid=0, key_data=0, busy=0. FSM enters IDLE and the round-robin pointer is 0.
- Accept at cycle T:
  - Non-USE ops and failed USE: response at T+1.
  - Successful USE: key_valid rises at T+1; the response comes in the cycle where key_valid & key_ready.
- Earliest next grant is the cycle after the response. Maximum throughput is 1 op per 2 cycles.
- Zeroize entered at cycle T: busy is high for NUM_SLOTS cycles starting T+1 (in ZEROIZE), and the first grant is possible at T+1+NUM_SLOTS.
- req_ready is combinational from req_valid and state (IDLE & !zeroize_all). It is never high outside IDLE.
- Slot updates take effect at the end of EXEC and are visible to the next op.

## Structure
- Package key_slot_pkg holds:
  - op encoding enum (WRITE/USE/LOCK/ZERO)
  - status encoding enum (OK/DENIED/EMPTY/ABORTED)
  - FSM state enum
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, enable
  - outputs: one-hot grant and binary grant index
  - the pointer register lives inside it and advances only on an enabled grant
- Slot storage, policy check and FSM live in the top module.

## Test plan
- Req0 WRITE slot1 = 0x0123…EF → OK at T+1. Req0 USE slot1 → key_valid at T+1 with data 0x0123…EF. With key_ready held low for 3 cycles, key_data stays stable; on acceptance, rsp OK with id 0.
- Req2 USE slot1 (owner 0) → DENIED, key_valid stays 0 and key_data stays 0. Req1 USE of empty slot3 → EMPTY.
- Req0 LOCK slot1 → OK. Req0 WRITE slot1 → DENIED and data unchanged. Req0 ZERO slot1 → OK, after which USE → EMPTY.
- All four requesters hold req_valid continuously → grants in order 0,1,2,3,0, one grant every 2 cycles.
- zeroize_all asserted during KEY_OUT → ABORTED response, key_valid drops next cycle, busy high for 4 cycles, all slots read back EMPTY.
- rst_n dropped mid-KEY_OUT → outputs go to reset values immediately (asynchronously). After release, USE of any slot → EMPTY.
